// File: rtl/coarse_delay_stop.sv
// Coarse (integer m_clk cycle) part of the programmed delay: trigger edge -> delay -> registered stop pulse.
// Optional macro COARSE_RETRIGGER_EN: an edge during DELAY restarts the sequence instead of counting a miss.
module coarse_delay_stop #(
  parameter int DLY_W  = 16,
  parameter int PW_W   = 8,
  parameter int MISS_W = 8
) (
  input  logic              m_clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [DLY_W-1:0]  delay_cycles,
  input  logic [PW_W-1:0]   pulse_cycles,
  input  logic              clr_miss,
  output logic              stop_pulse,
  output logic              busy,
  output logic              done,
  output logic [MISS_W-1:0] miss_cnt
);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  // state is the observation point for external checkers.
  state_t              state, state_nx;
  logic                trig_q;
  logic                trig_edge;
  logic [DLY_W-1:0]    dcnt, dcnt_nx;
  logic [PW_W-1:0]     pcnt, pcnt_nx;
  logic [PW_W-1:0]     pw_eff;
  logic                stop_nx, busy_nx, done_nx, miss_inc;
  logic [MISS_W-1:0]   miss_nx;

  assign trig_edge = trigger & ~trig_q;
  assign pw_eff    = (pulse_cycles == '0) ? PW_W'(1) : pulse_cycles;

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    pcnt_nx  = pcnt;
    stop_nx  = stop_pulse;
    busy_nx  = busy;
    done_nx  = 1'b0;
    miss_inc = 1'b0;
    case (state)
      IDLE: begin
        if (trig_edge) begin
          dcnt_nx  = delay_cycles;
          pcnt_nx  = pw_eff;
          busy_nx  = 1'b1;
          state_nx = DELAY;
        end
      end
      DELAY: begin
`ifdef COARSE_RETRIGGER_EN
        if (trig_edge) begin
          dcnt_nx = delay_cycles;
          pcnt_nx = pw_eff;
        end else
`else
        miss_inc = trig_edge;
`endif
        if (dcnt == '0) begin
          stop_nx  = 1'b1;
          state_nx = PULSE;
        end else begin
          dcnt_nx = dcnt - DLY_W'(1);
        end
      end
      PULSE: begin
        miss_inc = trig_edge;
        pcnt_nx  = pcnt - PW_W'(1);
        // Last pulse cycle: the falling edge of stop_pulse and done land together.
        if (pcnt == PW_W'(1)) begin
          stop_nx  = 1'b0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    miss_nx = miss_cnt;
    if (clr_miss)
      miss_nx = '0;
    else if (miss_inc && (miss_cnt != '1))
      miss_nx = miss_cnt + MISS_W'(1);
  end

  always_ff @(posedge m_clk) begin
    if (rst) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      dcnt       <= '0;
      pcnt       <= '0;
      stop_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nx;
      trig_q     <= trigger;
      dcnt       <= dcnt_nx;
      pcnt       <= pcnt_nx;
      stop_pulse <= stop_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      miss_cnt   <= miss_nx;
    end
  end

endmodule

// File: tb/tb_coarse_delay_stop.sv
// Bench for coarse_delay_stop: directed triggers push expected {busy rise, stop rise, done} cycles;
// a negedge monitor pops one entry per done strobe and compares.
module tb_coarse_delay_stop;

  logic        clk;
  logic        rst;
  logic        trigger;
  logic [15:0] delay_cycles;
  logic [7:0]  pulse_cycles;
  logic        clr_miss;
  logic        stop_pulse;
  logic        busy;
  logic        done;
  logic [7:0]  miss_cnt;

  coarse_delay_stop #(.DLY_W(16), .PW_W(8), .MISS_W(8)) dut (
    .m_clk        (clk),
    .rst          (rst),
    .trigger      (trigger),
    .delay_cycles (delay_cycles),
    .pulse_cycles (pulse_cycles),
    .clr_miss     (clr_miss),
    .stop_pulse   (stop_pulse),
    .busy         (busy),
    .done         (done),
    .miss_cnt     (miss_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [59:0] exp_q[$];

  task automatic push_exp(input int br, input int sr, input int dn);
    logic [19:0] a, b, c;
    a = br[19:0];
    b = sr[19:0];
    c = dn[19:0];
    exp_q.push_back({a, b, c});
  endtask

  // Normal run from an edge seen in cycle e.
  task automatic push_run(input int e, input int d, input int p);
    int w;
    w = (p == 0) ? 1 : p;
    push_exp(e + 1, e + d + 2, e + d + 2 + w);
  endtask

  // ---------------- monitor ----------------
  logic        busy_prev = 1'b0;
  logic        stop_prev = 1'b0;
  int          busy_rise = -1;
  int          stop_rise = -1;
  int          stop_cnt  = 0;
  logic [59:0] ent;

  always @(negedge clk) begin
    if (busy && !busy_prev) busy_rise = cyc;
    if (stop_pulse && !stop_prev) begin
      stop_rise = cyc;
      stop_cnt  = 0;
    end
    if (stop_pulse) stop_cnt++;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        ent = exp_q.pop_front();
        check("busy_rise_cycle", busy_rise, int'(ent[59:40]));
        check("stop_rise_cycle", stop_rise, int'(ent[39:20]));
        check("done_cycle", cyc, int'(ent[19:0]));
        check("stop_width", stop_cnt, int'(ent[19:0]) - int'(ent[39:20]));
        check("stop_low_at_done", stop_pulse, 0);
        check("busy_low_at_done", busy, 0);
      end
    end
    busy_prev = busy;
    stop_prev = stop_pulse;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic fire(input logic [15:0] d, input logic [7:0] p, output int e);
    delay_cycles = d;
    pulse_cycles = p;
    trigger      = 1'b1;
    e            = cyc;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", (n >= budget) ? 1 : 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e, e2, exp_miss;
    rst          = 1'b1;
    trigger      = 1'b0;
    delay_cycles = '0;
    pulse_cycles = '0;
    clr_miss     = 1'b0;
    step();
    step();
    check("rst_stop_pulse", stop_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    step();

    // delay 5, width 3; inputs change right after the edge
    step(); fire(16'd5, 8'd3, e); push_run(e, 5, 3);
    step(); trigger = 1'b0; delay_cycles = 16'd20; pulse_cycles = 8'd9;
    drain(2000);

    // delay 0, width 0 (treated as 1)
    step(); fire(16'd0, 8'd0, e); push_run(e, 0, 0);
    step(); trigger = 1'b0;
    drain(2000);

    // trigger held high for 20 cycles -> single run
    step(); fire(16'd2, 8'd2, e); push_run(e, 2, 2);
    goto(e + 20); trigger = 1'b0;
    drain(2000);
    check("held_trigger_miss", miss_cnt, 0);

    // second edge 3 cycles into a 10-cycle delay
    step(); fire(16'd10, 8'd2, e);
`ifdef COARSE_RETRIGGER_EN
    push_exp(e + 1, e + 15, e + 17);
`else
    push_run(e, 10, 2);
`endif
    step(); trigger = 1'b0;
    goto(e + 3); trigger = 1'b1;
    step(); trigger = 1'b0;
    drain(2000);
`ifdef COARSE_RETRIGGER_EN
    check("retrigger_miss", miss_cnt, 0);
`else
    check("delay_edge_miss", miss_cnt, 1);
`endif

    step(); clr_miss = 1'b1;
    step(); clr_miss = 1'b0;
    check("clr_miss_alone", miss_cnt, 0);

    // back-to-back: new edge in the done cycle
    step(); fire(16'd1, 8'd1, e); push_run(e, 1, 1);
    step(); trigger = 1'b0;
    goto(e + 4); fire(16'd1, 8'd1, e2); push_run(e2, 1, 1);
    step(); trigger = 1'b0;
    drain(2000);
    check("back_to_back_miss", miss_cnt, 0);

    // miss counter saturation: 127 edges in each of three long pulses
    for (int r = 0; r < 4; r++) begin
      step(); fire(16'd0, 8'd255, e); push_run(e, 0, 255);
      step(); trigger = 1'b0;
      if (r < 3) begin
        for (int k = 1; k <= 127; k++) begin
          goto(e + 2 * k); trigger = 1'b1;
          step(); trigger = 1'b0;
        end
        drain(2000);
        exp_miss = (127 * (r + 1) > 255) ? 255 : 127 * (r + 1);
        check("miss_cnt_accum", miss_cnt, exp_miss);
      end else begin
        goto(e + 2); trigger = 1'b1; clr_miss = 1'b1;
        step(); trigger = 1'b0; clr_miss = 1'b0;
        check("clr_beats_edge", miss_cnt, 0);
        drain(2000);
      end
    end

    // reset while stop_pulse is high, then a fresh run
    step(); fire(16'd3, 8'd5, e);
    step(); trigger = 1'b0;
    goto(e + 6);
    check("stop_high_before_rst", stop_pulse, 1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("rst_mid_stop", stop_pulse, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    goto(e + 30);
    step(); fire(16'd4, 8'd2, e); push_run(e, 4, 2);
    step(); trigger = 1'b0;
    drain(2000);

    check("queue_empty_at_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coarse_delay_stop.md
Name: coarse_delay_stop

Overview:
- Generates the stop pulse consumed by the IODELAY2-based fine delay stage. It produces the integer-clock-cycle (coarse) part of the programmed delay from a start trigger.
- A rising edge on trigger starts a programmable count of m_clk cycles, then drives stop_pulse high for a programmable number of cycles.
- The output is fully registered so it drives the fine delay's ODATAIN path glitch-free.
- Sits between the function-generator control registers and fine_delay_stop.

Parameters:
- DLY_W, 16, width of delay_cycles and the internal delay counter
- PW_W, 8, width of pulse_cycles and the internal pulse-width counter
- MISS_W, 8, width of the saturating missed-trigger counter

Ports:
- m_clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- trigger  input  1  start request, synchronous to m_clk; only rising edges act
- delay_cycles  input  DLY_W  coarse delay in m_clk cycles, sampled at trigger edge
- pulse_cycles  input  PW_W  stop pulse width in m_clk cycles, sampled at trigger edge; 0 is treated as 1
- clr_miss  input  1  synchronous clear of miss_cnt
- stop_pulse  output  1  registered stop pulse to fine_delay_stop
- busy  output  1  high while a delay or pulse is in progress
- done  output  1  one-cycle strobe on the cycle stop_pulse falls
- miss_cnt  output  MISS_W  saturating count of trigger edges ignored while busy

Behaviour:
- Clock and reset: one clock, m_clk. Reset rst is synchronous and active-high.
- Reset values: stop_pulse=0, busy=0, done=0, miss_cnt=0, trigger history register=0, state=IDLE, counters=0.
- Reset mid-operation: the sequence aborts, stop_pulse drops on the next edge, and no done is issued.
- Edge detect: trig_q registers trigger. edge = trigger & ~trig_q, evaluated each cycle. Trigger held high produces exactly one edge.
- FSM states: IDLE, DELAY, PULSE.
- IDLE: on edge, latch delay_cycles into dcnt and max(pulse_cycles,1) into pcnt, then go to DELAY; busy=1 from the next cycle.
- DELAY: if dcnt==0, go to PULSE and set stop_pulse=1. Otherwise decrement dcnt.
- PULSE: decrement pcnt. When pcnt==1, clear stop_pulse, assert done for one cycle, clear busy, and go to IDLE.
- Timing: call the cycle in which edge is seen cycle 0.
  - stop_pulse is high in cycles delay_cycles+2 through delay_cycles+1+W, where W=max(pulse_cycles,1).
  - done is high in cycle delay_cycles+2+W, coincident with stop_pulse=0 and busy=0.
- Back-to-back triggers: a new edge is accepted in the cycle done is high, and in any later cycle.
- Missed triggers: an edge while busy=1, in DELAY or PULSE, is ignored and increments miss_cnt. miss_cnt saturates at all-ones.
- clr_miss: has priority over an increment in the same cycle; the result is 0.
- Input sampling: delay_cycles and pulse_cycles changes after the edge have no effect on the running sequence.
- Maximum values: all-ones delay_cycles and pulse_cycles must run without wrap. Counters are exactly DLY_W and PW_W bits and count down only.

Optional Feature:
- Macro: COARSE_RETRIGGER_EN.
- Defined:
  - An edge in DELAY reloads dcnt and pcnt from the current inputs and restarts the delay from cycle 0 timing. miss_cnt is not incremented.
  - An edge in PULSE is still ignored and counted as a miss.
- Undefined: all edges while busy are ignored and counted, as above.

Test Plan:
- Reset, then trigger edge with delay_cycles=5, pulse_cycles=3 -> stop_pulse high in cycles 7,8,9; done=1 in cycle 10; busy high in cycles 1..9.
- delay_cycles=0, pulse_cycles=0 -> stop_pulse high in cycle 2 only; done in cycle 3.
- Trigger held high for 20 cycles, delay_cycles=2, pulse_cycles=2 -> exactly one pulse (cycles 4,5); miss_cnt stays 0.
- Second edge at cycle 3 of a delay_cycles=10 run, macro undefined -> original timing unchanged; miss_cnt=1.
  - Same stimulus with COARSE_RETRIGGER_EN -> stop_pulse in cycles 15+ relative to the first edge; miss_cnt=0.
- 300 edges during a long run with MISS_W=8 -> miss_cnt=255. Then clr_miss coincident with an edge -> miss_cnt=0.
- rst asserted while stop_pulse=1 -> stop_pulse=0 and busy=0 on the next edge; no done. A fresh edge afterwards gives normal timing.
